f1_win_reader: RTL and testbench
================================

Name: f1_win_reader

Overview:
- Downstream consumer of the conv-layer-1 feature RAM.
- Walks every KxK window of the IMG_W x IMG_H input feature map in raster order and drives the RAM byte read address.
- Absorbs the RAM's fixed 2-cycle read latency and streams window pixels to the conv1 MAC array over a valid/ready handshake with full backpressure.
- Output is stride 1, with no padding: for 32x32 input and K=5, that is 28x28 windows of 25 pixels each.

Parameters:
- IMG_W, 32, feature map width in pixels.
- IMG_H, 32, feature map height in pixels.
- K, 5, kernel edge length.
- ADDR_W, 10, RAM read address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width.
- RD_LAT, 2, RAM read latency in cycles.
- FIFO_D, 4, output buffer depth; must be >= RD_LAT+1.

Ports:
- rclk, in, 1, the single clock; also clocks the RAM read port.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a frame scan; ignored while busy=1.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse after the final pixel handshake.
- f1_raddr, out, ADDR_W, RAM read address.
- f1_rdata, in, DATA_W, RAM read data, valid RD_LAT cycles after its address.
- pix_valid, out, 1, pix_data is valid.
- pix_ready, in, 1, consumer accepts the pixel.
- pix_data, out, DATA_W, window pixel.
- pix_first, out, 1, pixel is (ky=0, kx=0) of its window.
- pix_last, out, 1, pixel is (ky=K-1, kx=K-1) of its window.
- frame_last, out, 1, pix_last of the final window.

Behaviour:
- Reset values: busy=0, done=0, f1_raddr=0, pix_valid=0, pix_first=0, pix_last=0, frame_last=0, pix_data=0.
- Reset is asynchronous and clears the FSM, all counters, the in-flight pipe and the FIFO.
- FSM states:
  - IDLE: on start -> RUN; counters oy=ox=ky=kx=0.
  - RUN: issue one read per cycle while credit is available. After issuing (oy=IMG_H-K, ox=IMG_W-K, ky=kx=K-1) -> DRAIN.
  - DRAIN: wait until the in-flight count and the FIFO are both empty -> IDLE, with a done pulse in that same transition cycle.
- Address: f1_raddr = (oy+ky)*IMG_W + (ox+kx). Use shift-add when IMG_W is a power of two. Compute at ADDR_W+1 bits and truncate; no overflow for legal parameters.
- Counter order: kx fastest, then ky, then ox, then oy. Each counter wraps to 0 at its limit and carries into the next.
- Read pipeline: a RD_LAT-deep shift register tracks issue-valid plus the first/last/frame_last tags. When it emerges, f1_rdata is pushed with those tags into the FIFO.
- Credit rule: issue only when (fifo_count + inflight + 1) <= FIFO_D. The FIFO therefore never overflows, and no read is ever discarded.
- Output: pix_valid = FIFO not empty. Pop when pix_valid && pix_ready.
- Simultaneous push and pop leave the count unchanged.
- Holding pix_ready low holds pix_data and the tags stable.
- start while busy: ignored, no effect.
- start asserted in the same cycle as done: ignored; a new frame needs start in IDLE.
- Reset mid-frame: immediate abort, no done pulse, outputs return to reset values.
- Frame totals: (IMG_H-K+1)*(IMG_W-K+1)*K*K pixel handshakes; 19600 at defaults.
- Throughput with pix_ready held at 1: one pixel per cycle after the initial RD_LAT fill.

Optional Feature:
- F1_WIN_PERF_EN, when defined:
  - Adds output perf_stall_cnt[15:0], which counts cycles with pix_valid && !pix_ready.
  - Saturates at 16'hFFFF.
  - Clears on an accepted start and on reset.
  - Holds its value after done.
- When not defined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package lenet_pkg holds:
  - IMG_W, IMG_H, K and OUT_W = IMG_W-K+1.
  - The FSM state encoding IDLE/RUN/DRAIN.
  - The pixel+tags record width DATA_W+3.
- One natural sub-module: f1_rd_fifo, a synchronous FIFO_D x (DATA_W+3) buffer with count output and rst_n clear.

Test Plan:
- Start with pix_ready=1 and RAM preloaded with mem[a]=a[7:0] -> first 25 addresses are 0-4, 32-36, 64-68, 96-100, 128-132. pix_first is set on data 0x00, pix_last on 0x84 (132), and the first pix_valid appears 3 cycles after start.
- Full frame with pix_ready=1 -> exactly 19600 handshakes, 784 pix_last pulses. The final window base address is 891 and the last address is 1023, with frame_last set on that pixel. done pulses once, then busy=0.
- Drop pix_ready for 10 cycles mid-window -> at most 4 values are outstanding (in flight plus FIFO). Data and tags hold steady, and the sequence resumes with no loss or duplication.
- Random pix_ready (50%) over a full frame -> the output stream matches the reference address model exactly.
- start pulsed while busy, then rst_n pulsed low mid-frame -> start is ignored. Reset clears all outputs within the asynchronous assertion, no done pulse occurs, and a subsequent start produces a correct full frame.
- With F1_WIN_PERF_EN defined and 37 stall cycles injected -> perf_stall_cnt=37 after done.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet conv1 feature-map datapath.
// Window geometry, FSM encoding and FIFO record width live here.
package lenet_pkg;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int PIX_W = 8;
  localparam int REC_W = PIX_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } win_state_e;

endpackage

// File: rtl/f1_win_reader_if.sv
// Window-pixel stream from the f1 window reader to the conv1 MAC array.
// Valid/ready handshake carrying the pixel and its window tags.
interface f1_win_reader_if #(
  parameter int DATA_W = 8
) ();

  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_first;
  logic              pix_last;
  logic              frame_last;

  modport master (
    output pix_valid, pix_data, pix_first, pix_last, frame_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_first, pix_last, frame_last,
    output pix_ready
  );

endinterface

// File: rtl/f1_rd_fifo.sv
// Small synchronous FIFO buffering RAM read data plus window tags.
// Caller guarantees no push when full and no pop when empty.
module f1_rd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 11,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = wdata;
      wp_d        = nxt(wp_q);
    end
    if (pop) begin
      rp_d = nxt(rp_q);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/f1_win_reader.sv
// Raster-order KxK window walker over the conv1 feature RAM.
// Optional stall counter port enabled by F1_WIN_PERF_EN.
module f1_win_reader
  import lenet_pkg::*;
#(
  parameter int IMG_W  = lenet_pkg::IMG_W,
  parameter int IMG_H  = lenet_pkg::IMG_H,
  parameter int K      = lenet_pkg::K,
  parameter int ADDR_W = 10,
  parameter int DATA_W = lenet_pkg::PIX_W,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] f1_raddr,
  input  logic [DATA_W-1:0] f1_rdata,
  f1_win_reader_if.master   pix
`ifdef F1_WIN_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int OW  = IMG_W - K + 1;
  localparam int OH  = IMG_H - K + 1;
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 1);
  localparam int KW  = $clog2(K + 1);
  localparam int AW1 = ADDR_W + 1;
  localparam int RW  = DATA_W + 3;
  localparam int CW  = $clog2(FIFO_D + 1);
  localparam int LW  = $clog2(IMG_W);

  win_state_e state_q, state_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] fst_q, fst_d;
  logic [RD_LAT-1:0] lst_q, lst_d;
  logic [RD_LAT-1:0] frl_q, frl_d;

  logic          issue;
  logic          kx_end, ky_end, ox_end, oy_end;
  logic          win_first, win_last, fr_last;
  logic          push, pop, pv;
  logic [RW-1:0] wrec, head;
  logic [CW-1:0] fifo_cnt;
  int            inflight;

  logic [AW1-1:0] row_w, col_w, addr_w;
  logic           addr_unused;

  assign row_w = AW1'(oy_q) + AW1'(ky_q);
  assign col_w = AW1'(ox_q) + AW1'(kx_q);

  if ((IMG_W & (IMG_W - 1)) == 0) begin : g_shift
    assign addr_w = (row_w << LW) + col_w;
  end else begin : g_mul
    assign addr_w = row_w * AW1'(IMG_W) + col_w;
  end

  assign f1_raddr    = addr_w[ADDR_W-1:0];
  assign addr_unused = addr_w[ADDR_W];

  assign kx_end    = (kx_q == KW'(K - 1));
  assign ky_end    = (ky_q == KW'(K - 1));
  assign ox_end    = (ox_q == XW'(OW - 1));
  assign oy_end    = (oy_q == YW'(OH - 1));
  assign win_first = (kx_q == '0) && (ky_q == '0);
  assign win_last  = kx_end && ky_end;
  assign fr_last   = win_last && ox_end && oy_end;

  // Reserve a FIFO slot for every read before it leaves, so nothing is dropped.
  assign inflight = $countones(vld_q);
  assign issue    = (state_q == RUN) &&
                    ((int'(fifo_cnt) + inflight + 1) <= FIFO_D);

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      RUN: begin
        if (issue) begin
          kx_d = kx_end ? '0 : kx_q + KW'(1);
          if (kx_end) begin
            ky_d = ky_end ? '0 : ky_q + KW'(1);
            if (ky_end) begin
              ox_d = ox_end ? '0 : ox_q + XW'(1);
              if (ox_end) begin
                oy_d = oy_end ? '0 : oy_q + YW'(1);
              end
            end
          end
          if (fr_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == 0) && (fifo_cnt == '0)) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(issue);
    fst_d = (fst_q << 1) | RD_LAT'(issue && win_first);
    lst_d = (lst_q << 1) | RD_LAT'(issue && win_last);
    frl_d = (frl_q << 1) | RD_LAT'(issue && fr_last);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      vld_q   <= '0;
      fst_q   <= '0;
      lst_q   <= '0;
      frl_q   <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      vld_q   <= vld_d;
      fst_q   <= fst_d;
      lst_q   <= lst_d;
      frl_q   <= frl_d;
    end
  end

  assign push = vld_q[RD_LAT-1];
  assign wrec = {frl_q[RD_LAT-1], lst_q[RD_LAT-1],
                 fst_q[RD_LAT-1], f1_rdata};

  f1_rd_fifo #(
    .DEPTH (FIFO_D),
    .W     (RW)
  ) u_fifo (
    .clk   (rclk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wrec),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt)
  );

  // Outputs are masked to zero when the FIFO is empty.
  assign pv             = (fifo_cnt != '0);
  assign pop            = pv && pix.pix_ready;
  assign pix.pix_valid  = pv;
  assign pix.pix_data   = pv ? head[DATA_W-1:0] : '0;
  assign pix.pix_first  = pv && head[DATA_W];
  assign pix.pix_last   = pv && head[DATA_W+1];
  assign pix.frame_last = pv && head[DATA_W+2];
  assign busy           = (state_q != IDLE);

`ifdef F1_WIN_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if (pv && !pix.pix_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_f1_win_reader.sv
// Bench for f1_win_reader: 2-cycle RAM model, window address reference,
// full-frame, backpressure, random ready, start-while-busy and reset abort.
module tb_f1_win_reader;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int KK   = 5;
  localparam int OWN  = W - KK + 1;
  localparam int OHN  = H - KK + 1;
  localparam int NPIX = OWN * OHN * KK * KK;
  localparam int NWIN = OWN * OHN;
  localparam int FD   = 4;

  logic       rclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [9:0] f1_raddr;
  logic [7:0] f1_rdata;
`ifdef F1_WIN_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  logic [7:0] mem [1024];
  logic [7:0] r1, r2;

  int  e_addr  [NPIX];
  bit  e_first [NPIX];
  bit  e_last  [NPIX];
  bit  e_fl    [NPIX];

  int errors = 0;
  int checks = 0;

  f1_win_reader_if #(.DATA_W(8)) pif ();

  f1_win_reader dut (
    .rclk     (rclk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .f1_raddr (f1_raddr),
    .f1_rdata (f1_rdata),
    .pix      (pif)
`ifdef F1_WIN_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    r1 <= mem[f1_raddr];
    r2 <= r1;
  end
  assign f1_rdata = r2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    int n = 0;
    for (int oy = 0; oy < OHN; oy++)
      for (int ox = 0; ox < OWN; ox++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            e_addr[n]  = (oy + ky) * W + (ox + kx);
            e_first[n] = (ky == 0) && (kx == 0);
            e_last[n]  = (ky == KK - 1) && (kx == KK - 1);
            e_fl[n]    = e_last[n] && (oy == OHN - 1) && (ox == OWN - 1);
            n++;
          end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_raddr"}, f1_raddr, 0);
    chk({tag, "_valid"}, pif.pix_valid, 0);
    chk({tag, "_data"}, pif.pix_data, 0);
    chk({tag, "_first"}, pif.pix_first, 0);
    chk({tag, "_last"}, pif.pix_last, 0);
    chk({tag, "_flast"}, pif.frame_last, 0);
  endtask

  // mode 0: ready=1, 1: random ready, 2: scripted 10+27 stall cycles
  task automatic run_frame(input int mode, input int abort_at,
                           input bit chk_first);
    int   idx = 0, cyc = 1, nlast = 0, issued = 0, stalls = 0;
    int   drop1 = 10, drop2 = 27;
    bit   fin = 0, aborted = 0, stalled = 0, seen_v = 0;
    logic r;
    logic [10:0] prev;
    @(negedge rclk);
    start = 1'b1;
    pif.pix_ready = 1'b1;
    @(negedge rclk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!fin && cyc < 60000) begin
      if (abort_at >= 0 && idx >= abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge rclk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      start = (mode == 0 && cyc == 100);
      unique case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = 1'b1;
          if (pif.pix_valid && idx == 1003 && drop1 > 0) begin
            r = 1'b0;
            drop1--;
          end
          if (pif.pix_valid && idx == 5012 && drop2 > 0) begin
            r = 1'b0;
            drop2--;
          end
        end
      endcase
      pif.pix_ready = r;
      if (stalled) begin
        chk("hold_valid", pif.pix_valid, 1);
        chk("hold_rec", {pif.frame_last, pif.pix_last, pif.pix_first,
                         pif.pix_data}, prev);
      end
      stalled = pif.pix_valid && !r;
      if (stalled) begin
        stalls++;
        prev = {pif.frame_last, pif.pix_last, pif.pix_first, pif.pix_data};
      end
      if (chk_first && pif.pix_valid && !seen_v) chk("first_valid_cyc", cyc, 4);
      if (pif.pix_valid) seen_v = 1;
      if (dut.issue) begin
        if (issued < NPIX) chk("raddr", f1_raddr, e_addr[issued]);
        else chk("extra_issue", issued, NPIX - 1);
        issued++;
      end
      if (pif.pix_valid && r) begin
        if (idx < NPIX) begin
          chk("pix_data", pif.pix_data, mem[e_addr[idx]]);
          chk("pix_first", pif.pix_first, e_first[idx]);
          chk("pix_last", pif.pix_last, e_last[idx]);
          chk("frame_last", pif.frame_last, e_fl[idx]);
        end else begin
          chk("extra_pix", idx, NPIX - 1);
        end
        if (pif.pix_last) nlast++;
        idx++;
      end
      chk("outstanding_le4", (issued - idx) <= FD, 1);
      if (done) begin
        chk("done_at_total", idx, NPIX);
        fin = 1;
        start = 1'b1;
      end
      @(negedge rclk);
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      chk("abort_no_done", fin, 0);
    end else begin
      chk("done_seen", fin, 1);
      chk("done_one_pulse", done, 0);
      chk("busy_after_done", busy, 0);
      chk("n_handshakes", idx, NPIX);
      chk("n_pix_last", nlast, NWIN);
`ifdef F1_WIN_PERF_EN
      chk("perf_stall_cnt", perf_stall_cnt, stalls);
      if (mode == 2) chk("perf_is_37", perf_stall_cnt, 37);
`endif
      if (mode == 2) chk("stalls_injected", stalls, 37);
      repeat (3) @(negedge rclk);
      chk("idle_stays_idle", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pif.pix_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    build_model();
    #12;
    chk_reset_outputs("reset");
    @(negedge rclk);
    rst_n = 1'b1;
    @(negedge rclk);
    chk("idle_busy", busy, 0);

    run_frame(0, -1, 1'b1);

    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    run_frame(1, -1, 1'b0);

    run_frame(0, 500, 1'b0);
    @(negedge rclk);
    chk("post_abort_busy", busy, 0);
    chk("post_abort_valid", pif.pix_valid, 0);

    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    run_frame(2, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
